mesm6_membus_arb: RTL and testbench



---
 rtl/mesm6_membus_arb.sv | 160 ++++++++++++++++
 tb/tb_mesm6_membus_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_membus_arb.sv
// Two-port arbiter sharing one single-ported word memory between the instruction and data buses.
// Define MESM6_IBUF_EN to add a one-word instruction buffer that completes repeated fetches without memory.
module mesm6_membus_arb #(
  parameter int unsigned ADDR_BITS = 15,
  parameter int unsigned DATA_BITS = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ibus_fetch,
  input  logic [ADDR_BITS-1:0] ibus_addr,
  output logic [DATA_BITS-1:0] ibus_input,
  output logic                 ibus_done,
  input  logic                 dbus_read,
  input  logic                 dbus_write,
  input  logic [ADDR_BITS-1:0] dbus_addr,
  input  logic [DATA_BITS-1:0] dbus_output,
  output logic [DATA_BITS-1:0] dbus_input,
  output logic                 dbus_done,
  output logic                 mem_valid,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IACC,
    S_DACC,
    S_IRESP,
    S_DRESP
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [DATA_BITS-1:0]   ibus_input_q, ibus_input_d;
  logic [DATA_BITS-1:0]   dbus_input_q, dbus_input_d;

  logic                   ibuf_hit;
  logic [DATA_BITS-1:0]   ibuf_rd_data;

`ifdef MESM6_IBUF_EN
  logic [ADDR_BITS-1:0]   ibuf_tag_q, ibuf_tag_d;
  logic [DATA_BITS-1:0]   ibuf_data_q, ibuf_data_d;
  logic                   ibuf_valid_q, ibuf_valid_d;

  assign ibuf_hit     = ibuf_valid_q && (ibuf_tag_q == ibus_addr);
  assign ibuf_rd_data = ibuf_data_q;
`else
  assign ibuf_hit     = 1'b0;
  assign ibuf_rd_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    ibus_input_d = ibus_input_q;
    dbus_input_d = dbus_input_q;
`ifdef MESM6_IBUF_EN
    ibuf_tag_d   = ibuf_tag_q;
    ibuf_data_d  = ibuf_data_q;
    ibuf_valid_d = ibuf_valid_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Data requests win; read+write together is treated as a write.
        if (dbus_read || dbus_write) begin
          addr_d  = dbus_addr;
          wdata_d = dbus_output;
          write_d = dbus_write;
          state_d = S_DACC;
        end else if (ibus_fetch) begin
          if (ibuf_hit) begin
            ibus_input_d = ibuf_rd_data;
            state_d      = S_IRESP;
          end else begin
            addr_d  = ibus_addr;
            write_d = 1'b0;
            state_d = S_IACC;
          end
        end
      end
      S_IACC: begin
        if (mem_ready) begin
          ibus_input_d = mem_rdata;
`ifdef MESM6_IBUF_EN
          ibuf_tag_d   = addr_q;
          ibuf_data_d  = mem_rdata;
          ibuf_valid_d = 1'b1;
`endif
          state_d      = S_IRESP;
        end
      end
      S_DACC: begin
        if (mem_ready) begin
          if (!write_q) begin
            dbus_input_d = mem_rdata;
          end
`ifdef MESM6_IBUF_EN
          if (write_q && (addr_q == ibuf_tag_q)) begin
            ibuf_valid_d = 1'b0;
          end
`endif
          state_d = S_DRESP;
        end
      end
      S_IRESP: state_d = S_IDLE;
      S_DRESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      ibus_input_q <= '0;
      dbus_input_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      ibus_input_q <= ibus_input_d;
      dbus_input_q <= dbus_input_d;
    end
  end

`ifdef MESM6_IBUF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_tag_q   <= '0;
      ibuf_data_q  <= '0;
      ibuf_valid_q <= 1'b0;
    end else begin
      ibuf_tag_q   <= ibuf_tag_d;
      ibuf_data_q  <= ibuf_data_d;
      ibuf_valid_q <= ibuf_valid_d;
    end
  end
`endif

  // All outputs derive from registered state only, so no input reaches them combinationally.
  assign mem_valid  = (state_q == S_IACC) || (state_q == S_DACC);
  assign mem_write  = write_q && (state_q == S_DACC);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ibus_done  = (state_q == S_IRESP);
  assign dbus_done  = (state_q == S_DRESP);
  assign ibus_input = ibus_input_q;
  assign dbus_input = dbus_input_q;

endmodule

// File: tb/tb_mesm6_membus_arb.sv
// Directed self-checking bench for mesm6_membus_arb; the bench itself plays the memory.
// Inputs are driven and outputs checked on the falling edge, mid-cycle.
module tb_mesm6_membus_arb;

  localparam int unsigned AB = 15;
  localparam int unsigned DB = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          ibus_fetch;
  logic [AB-1:0] ibus_addr;
  logic [DB-1:0] ibus_input;
  logic          ibus_done;
  logic          dbus_read;
  logic          dbus_write;
  logic [AB-1:0] dbus_addr;
  logic [DB-1:0] dbus_output;
  logic [DB-1:0] dbus_input;
  logic          dbus_done;
  logic          mem_valid;
  logic          mem_write;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata;
  logic [DB-1:0] mem_rdata;
  logic          mem_ready;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  localparam logic [DB-1:0] W_FETCH = 48'o1234_5670_1234_5670;
  localparam logic [DB-1:0] W_DRD   = 48'h0A0A_0B0B_0C0C;
  localparam logic [DB-1:0] W_IRD   = 48'h1111_2222_3333;
  localparam logic [DB-1:0] W_WR    = 48'hFFFF_0000_FFFF;
  localparam logic [DB-1:0] W_B1    = 48'h0000_0000_0200;
  localparam logic [DB-1:0] W_NEW   = 48'hDEAD_BEEF_CAFE;

  mesm6_membus_arb #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ibus_fetch = 1'b0; ibus_addr = '0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_addr = '0; dbus_output = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", mem_valid, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_idone", ibus_done, 0);
    chk("rst_ddone", dbus_done, 0);
    chk("rst_iin", ibus_input, 0);
    chk("rst_din", dbus_input, 0);
    reset = 1'b0;
    cyc();

    // Zero-wait fetch of 0o100.
    ibus_fetch = 1'b1; ibus_addr = 15'o100;
    cyc();
    chk("f_valid_c1", mem_valid, 1);
    chk("f_addr_c1", mem_addr, 15'o100);
    chk("f_write_c1", mem_write, 0);
    chk("f_done_c1", ibus_done, 0);
    mem_ready = 1'b1; mem_rdata = W_FETCH;
    cyc();
    chk("f_done_c2", ibus_done, 1);
    chk("f_valid_c2", mem_valid, 0);
    chk("f_data_c2", ibus_input, W_FETCH);
    chk("f_ddone_c2", dbus_done, 0);
    mem_ready = 1'b0; mem_rdata = '0; ibus_fetch = 1'b0;
    cyc();
    chk("f_done_c3", ibus_done, 0);
    chk("f_hold_c3", ibus_input, W_FETCH);

    // Collision: data read of 7 must go first, fetch of 5 follows.
    ibus_fetch = 1'b1; ibus_addr = 15'd5;
    dbus_read = 1'b1; dbus_addr = 15'd7;
    cyc();
    chk("c_valid_c1", mem_valid, 1);
    chk("c_addr_c1", mem_addr, 7);
    chk("c_write_c1", mem_write, 0);
    mem_ready = 1'b1; mem_rdata = W_DRD;
    cyc();
    chk("c_ddone_c2", dbus_done, 1);
    chk("c_idone_c2", ibus_done, 0);
    chk("c_din_c2", dbus_input, W_DRD);
    chk("c_valid_c2", mem_valid, 0);
    mem_ready = 1'b0; mem_rdata = '0; dbus_read = 1'b0;
    cyc();
    chk("c_valid_c3", mem_valid, 0);
    chk("c_ddone_c3", dbus_done, 0);
    cyc();
    chk("c_valid_c4", mem_valid, 1);
    chk("c_addr_c4", mem_addr, 5);
    mem_ready = 1'b1; mem_rdata = W_IRD;
    cyc();
    chk("c_idone_c5", ibus_done, 1);
    chk("c_iin_c5", ibus_input, W_IRD);
    chk("c_din_hold_c5", dbus_input, W_DRD);
    mem_ready = 1'b0; mem_rdata = '0; ibus_fetch = 1'b0;
    cyc();
    chk("c_idone_c6", ibus_done, 0);

    // Write of 0o77 with ready in cycle 4; request lines change mid-access to prove latching.
    dbus_write = 1'b1; dbus_addr = 15'o77; dbus_output = W_WR;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("w_valid_c%0d", i), mem_valid, 1);
      chk($sformatf("w_write_c%0d", i), mem_write, 1);
      chk($sformatf("w_addr_c%0d", i), mem_addr, 15'o77);
      chk($sformatf("w_wdata_c%0d", i), mem_wdata, W_WR);
      chk($sformatf("w_ddone_c%0d", i), dbus_done, 0);
      dbus_addr = 15'd1; dbus_output = 48'h5555_5555_5555;
      if (i == 4) begin
        mem_ready = 1'b1; mem_rdata = 48'h0000_0000_0123;
      end
      cyc();
    end
    chk("w_ddone_c5", dbus_done, 1);
    chk("w_din_c5", dbus_input, W_DRD);
    chk("w_valid_c5", mem_valid, 0);
    mem_ready = 1'b0; mem_rdata = '0; dbus_write = 1'b0;
    cyc();
    chk("w_ddone_c6", dbus_done, 0);

    // Reset in the middle of a data read; a stray ready afterwards must be ignored.
    dbus_read = 1'b1; dbus_addr = 15'd3;
    cyc();
    chk("r_valid_c1", mem_valid, 1);
    reset = 1'b1;
    cyc();
    chk("r_valid_c2", mem_valid, 0);
    chk("r_addr_c2", mem_addr, 0);
    chk("r_iin_c2", ibus_input, 0);
    chk("r_din_c2", dbus_input, 0);
    chk("r_ddone_c2", dbus_done, 0);
    reset = 1'b0; dbus_read = 1'b0; mem_ready = 1'b1; mem_rdata = 48'h7777_7777_7777;
    cyc();
    chk("r_ddone_c3", dbus_done, 0);
    chk("r_idone_c3", ibus_done, 0);
    chk("r_valid_c3", mem_valid, 0);
    mem_ready = 1'b0; mem_rdata = '0;
    cyc();
    chk("r_ddone_c4", dbus_done, 0);
    chk("r_din_c4", dbus_input, 0);

    // First fetch of 0o200 always goes to memory.
    ibus_fetch = 1'b1; ibus_addr = 15'o200;
    cyc();
    chk("b1_valid_c1", mem_valid, 1);
    chk("b1_addr_c1", mem_addr, 15'o200);
    mem_ready = 1'b1; mem_rdata = W_B1;
    cyc();
    chk("b1_done_c2", ibus_done, 1);
    chk("b1_iin_c2", ibus_input, W_B1);
    mem_ready = 1'b0; mem_rdata = '0; ibus_fetch = 1'b0;
    cyc();

    // Second fetch of 0o200: buffer hit when enabled, memory access otherwise.
    ibus_fetch = 1'b1; ibus_addr = 15'o200;
    cyc();
`ifdef MESM6_IBUF_EN
    chk("b2_done_c1", ibus_done, 1);
    chk("b2_valid_c1", mem_valid, 0);
    chk("b2_iin_c1", ibus_input, W_B1);
    ibus_fetch = 1'b0;
    cyc();
    chk("b2_done_c2", ibus_done, 0);
    chk("b2_valid_c2", mem_valid, 0);
`else
    chk("b2_done_c1", ibus_done, 0);
    chk("b2_valid_c1", mem_valid, 1);
    chk("b2_addr_c1", mem_addr, 15'o200);
    mem_ready = 1'b1; mem_rdata = W_B1;
    cyc();
    chk("b2_done_c2", ibus_done, 1);
    chk("b2_iin_c2", ibus_input, W_B1);
    mem_ready = 1'b0; mem_rdata = '0; ibus_fetch = 1'b0;
    cyc();
`endif

    // Write 0o200, then fetch it again: must reach memory and return the new word.
    dbus_write = 1'b1; dbus_addr = 15'o200; dbus_output = W_NEW;
    cyc();
    chk("i_wvalid_c1", mem_valid, 1);
    chk("i_wwrite_c1", mem_write, 1);
    mem_ready = 1'b1;
    cyc();
    chk("i_ddone_c2", dbus_done, 1);
    mem_ready = 1'b0; dbus_write = 1'b0;
    cyc();
    ibus_fetch = 1'b1; ibus_addr = 15'o200;
    cyc();
    chk("i_fdone_c1", ibus_done, 0);
    chk("i_fvalid_c1", mem_valid, 1);
    chk("i_faddr_c1", mem_addr, 15'o200);
    mem_ready = 1'b1; mem_rdata = W_NEW;
    cyc();
    chk("i_fdone_c2", ibus_done, 1);
    chk("i_fiin_c2", ibus_input, W_NEW);
    mem_ready = 1'b0; mem_rdata = '0; ibus_fetch = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
